// File: rtl/lvds_frame_sequencer.sv
// LVDS frame sequencer: frames FIFO-fed I/Q samples for a serializer, one frame per strobe edge.
// Define LVDS_SEQ_CW_EN to enable constant-carrier (cw_mode) frames.

module lvds_frame_sequencer #(
    parameter int unsigned SAMPLE_W   = 13,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    transmit,
    input  logic                    cw_mode,
    input  logic [3:0]              gap_cfg,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SAMPLE_W-1:0]     s_i,
    input  logic [SAMPLE_W-1:0]     s_q,
    input  logic                    s_last,
    input  logic                    frame_strobe,
    output logic [2*SAMPLE_W+5:0]   frame_data,
    output logic                    busy,
    output logic                    msg_done,
    output logic                    underrun
);

    localparam int unsigned FRAME_W = 2*SAMPLE_W + 6;
    localparam int unsigned ENTRY_W = 2*SAMPLE_W + 1;
    localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW      = AW + 1;

    localparam logic [SAMPLE_W-1:0] CW_SAMPLE = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [FRAME_W-1:0]  TRAILER   =
        {2'b10, {(SAMPLE_W+1){1'b0}}, 2'b01, {(SAMPLE_W+1){1'b0}}};

    typedef enum logic [1:0] {IDLE, GAP, DATA, TRAIL} state_t;

    state_t               state, state_n;
    logic                 strobe_d, transmit_d, pending;
    logic                 edge_c, tx_rise_c, pending_clr_c;
    logic [3:0]           cnt, cnt_n, gap_max_c;
    logic [FRAME_W-1:0]   frame_n;
    logic                 busy_n, msg_done_n, underrun_n;
    logic                 last_r, last_n;
    logic                 pop_c, push_c, full_c, empty_c;
    logic [AW:0]          wr_ptr, rd_ptr;
    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic                 head_last;
    logic [SAMPLE_W-1:0]  head_i, head_q, di_c, dq_c;
    logic                 cw_c;

`ifdef LVDS_SEQ_CW_EN
    assign cw_c = cw_mode;
`else
    logic cw_unused;
    assign cw_unused = cw_mode;
    assign cw_c      = 1'b0;
`endif

    assign edge_c    = frame_strobe & ~strobe_d;
    assign tx_rise_c = transmit & ~transmit_d;
    assign gap_max_c = (gap_cfg == 4'd0) ? 4'd1 : gap_cfg;

    // Sample FIFO: extra pointer bit distinguishes full from empty.
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty_c = (wr_ptr == rd_ptr);
    assign s_ready = ~full_c;
    assign push_c  = s_valid & ~full_c;
    assign {head_last, head_i, head_q} = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr[AW-1:0]] <= {s_last, s_i, s_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    assign di_c = cw_c ? CW_SAMPLE : head_i;
    assign dq_c = cw_c ? CW_SAMPLE : head_q;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            frame_data <= '0;
            busy       <= 1'b0;
            msg_done   <= 1'b0;
            underrun   <= 1'b0;
            cnt        <= 4'd0;
            last_r     <= 1'b0;
            strobe_d   <= 1'b1;
            transmit_d <= 1'b1;
            pending    <= 1'b0;
        end else begin
            state      <= state_n;
            frame_data <= frame_n;
            busy       <= busy_n;
            msg_done   <= msg_done_n;
            underrun   <= underrun_n;
            cnt        <= cnt_n;
            last_r     <= last_n;
            strobe_d   <= frame_strobe;
            transmit_d <= transmit;
            if (pending_clr_c)
                pending <= 1'b0;
            else if (tx_rise_c && state == IDLE)
                pending <= 1'b1;
        end
    end

    // Next state: everything holds except on a strobe edge; msg_done is a single-cycle pulse.
    always_comb begin
        state_n       = state;
        frame_n       = frame_data;
        busy_n        = busy;
        underrun_n    = underrun;
        cnt_n         = cnt;
        last_n        = last_r;
        msg_done_n    = 1'b0;
        pop_c         = 1'b0;
        pending_clr_c = 1'b0;
        if (edge_c) begin
            frame_n = '0;
            case (state)
                IDLE: begin
                    if (pending) begin
                        pending_clr_c = 1'b1;
                        cnt_n         = 4'd0;
                        underrun_n    = 1'b0;
                        busy_n        = 1'b1;
                        state_n       = GAP;
                    end
                end
                GAP: begin
                    if (cnt < gap_max_c) begin
                        cnt_n = cnt + 4'd1;
                    end else if (cw_c || !empty_c) begin
                        frame_n = {2'b10, di_c, 1'b1, 2'b01, dq_c, 1'b0};
                        pop_c   = ~cw_c;
                        last_n  = cw_c ? 1'b0 : head_last;
                        state_n = DATA;
                    end else begin
                        underrun_n = 1'b1;
                    end
                end
                DATA: begin
                    if (last_r || (cw_c && !transmit)) begin
                        frame_n    = TRAILER;
                        msg_done_n = 1'b1;
                        state_n    = TRAIL;
                    end else begin
                        cnt_n   = 4'd0;
                        state_n = GAP;
                    end
                end
                TRAIL: begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lvds_frame_sequencer.sv
// Directed self-checking bench for lvds_frame_sequencer (default parameters).

module tb_lvds_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        transmit;
    logic        cw_mode;
    logic [3:0]  gap_cfg;
    logic        s_valid;
    logic        s_ready;
    logic [12:0] s_i;
    logic [12:0] s_q;
    logic        s_last;
    logic        frame_strobe;
    logic [31:0] frame_data;
    logic        busy;
    logic        msg_done;
    logic        underrun;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] fr;
    logic        md1, md2;
    logic [31:0] exp_b [11];
    int          md_seen;

    always #5 clk = ~clk;

    lvds_frame_sequencer #(.SAMPLE_W(13), .FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .transmit     (transmit),
        .cw_mode      (cw_mode),
        .gap_cfg      (gap_cfg),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_i          (s_i),
        .s_q          (s_q),
        .s_last       (s_last),
        .frame_strobe (frame_strobe),
        .frame_data   (frame_data),
        .busy         (busy),
        .msg_done     (msg_done),
        .underrun     (underrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One strobe edge; captures the new frame and msg_done one and two clocks later.
    task automatic strobe_edge();
        @(negedge clk) frame_strobe = 1'b1;
        @(negedge clk);
        fr  = frame_data;
        md1 = msg_done;
        frame_strobe = 1'b0;
        @(negedge clk);
        md2 = msg_done;
    endtask

    task automatic tx_pulse();
        @(negedge clk) transmit = 1'b1;
        @(negedge clk) transmit = 1'b0;
    endtask

    task automatic push(input logic [12:0] i, input logic [12:0] q, input logic last);
        @(negedge clk);
        s_valid = 1'b1;
        s_i     = i;
        s_q     = q;
        s_last  = last;
        @(negedge clk) s_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; transmit = 1'b0; cw_mode = 1'b0; gap_cfg = 4'd0;
        s_valid = 1'b0; s_i = '0; s_q = '0; s_last = 1'b0; frame_strobe = 1'b0;
        exp_b = '{32'h0, 32'h0, 32'h8001_4000, 32'h0, 32'h0, 32'hBFFF_7FFE,
                  32'h0, 32'h0, 32'h8003_4004, 32'h8000_4000, 32'h0};
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_frame", frame_data, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(msg_done), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd1);

        // Single-sample message, gap 3.
        gap_cfg = 4'd3;
        push(13'h0123, 13'h1ABC, 1'b1);
        tx_pulse();
        for (int k = 0; k < 4; k++) begin
            strobe_edge();
            check("a_gap", fr, 32'h0);
        end
        check("a_busy", 32'(busy), 32'd1);
        strobe_edge();
        check("a_data", fr, 32'h8247_7578);
        check("a_data_nodone", 32'(md1), 32'd0);
        strobe_edge();
        check("a_trail", fr, 32'h8000_4000);
        check("a_done_hi", 32'(md1), 32'd1);
        check("a_done_lo", 32'(md2), 32'd0);
        strobe_edge();
        check("a_tail", fr, 32'h0);
        check("a_idle", 32'(busy), 32'd0);

        // Three samples, gap_cfg 0 behaves as 1.
        gap_cfg = 4'd0;
        push(13'h0000, 13'h0000, 1'b0);
        push(13'h1FFF, 13'h1FFF, 1'b0);
        push(13'h0001, 13'h0002, 1'b1);
        tx_pulse();
        for (int k = 0; k < 11; k++) begin
            strobe_edge();
            check("b_seq", fr, exp_b[k]);
        end
        check("b_idle", 32'(busy), 32'd0);

        // Underrun: empty FIFO at the data slot.
        gap_cfg = 4'd1;
        tx_pulse();
        strobe_edge();
        strobe_edge();
        check("c_no_underrun_yet", 32'(underrun), 32'd0);
        strobe_edge();
        check("c_starve_frame", fr, 32'h0);
        check("c_underrun", 32'(underrun), 32'd1);
        strobe_edge();
        check("c_retry_frame", fr, 32'h0);
        push(13'h0001, 13'h0002, 1'b1);
        strobe_edge();
        check("c_late_data", fr, 32'h8003_4004);
        check("c_underrun_held", 32'(underrun), 32'd1);
        strobe_edge();
        check("c_trail", fr, 32'h8000_4000);
        strobe_edge();
        check("c_idle", 32'(busy), 32'd0);
        check("c_underrun_sticky", 32'(underrun), 32'd1);

        // FIFO fill to depth, ninth sample waits for the first pop.
        for (int k = 1; k <= 8; k++) begin
            check("d_ready", 32'(s_ready), 32'd1);
            push(13'(k), 13'h0, 1'b0);
        end
        check("d_full", 32'(s_ready), 32'd0);
        @(negedge clk);
        s_valid = 1'b1; s_i = 13'd9; s_q = 13'h0; s_last = 1'b1;
        tx_pulse();
        strobe_edge();
        check("d_underrun_clr", 32'(underrun), 32'd0);
        strobe_edge();
        check("d_still_full", 32'(s_ready), 32'd0);
        strobe_edge();
        check("d_data1", fr, 32'h8003_4000);
        s_valid = 1'b0;
        check("d_ninth_taken", 32'(s_ready), 32'd0);
        for (int k = 2; k <= 9; k++) begin
            strobe_edge();
            check("d_gap0", fr, 32'h0);
            strobe_edge();
            check("d_gap1", fr, 32'h0);
            strobe_edge();
            check("d_data", fr, {16'h8001 | 16'(k << 1), 16'h4000});
        end
        strobe_edge();
        check("d_trail", fr, 32'h8000_4000);
        check("d_done", 32'(md1), 32'd1);
        strobe_edge();
        check("d_idle", 32'(busy), 32'd0);
        check("d_empty", 32'(s_ready), 32'd1);

        // Reset mid-gap, strobe held high across release.
        gap_cfg = 4'd3;
        push(13'h0123, 13'h1ABC, 1'b1);
        tx_pulse();
        strobe_edge();
        strobe_edge();
        @(negedge clk);
        reset = 1'b1;
        frame_strobe = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("e_frame", frame_data, 32'h0);
        check("e_busy", 32'(busy), 32'd0);
        check("e_underrun", 32'(underrun), 32'd0);
        check("e_ready", 32'(s_ready), 32'd1);
        md_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (msg_done) md_seen++;
        end
        check("e_no_done", 32'(md_seen), 32'd0);
        tx_pulse();
        @(negedge clk);
        check("e_no_edge", 32'(busy), 32'd0);
        frame_strobe = 1'b0;
        push(13'h0123, 13'h1ABC, 1'b1);
        strobe_edge();
        check("e_start", 32'(busy), 32'd1);
        for (int k = 0; k < 3; k++) begin
            strobe_edge();
            check("e_gap", fr, 32'h0);
        end
        strobe_edge();
        check("e_data", fr, 32'h8247_7578);
        strobe_edge();
        check("e_trail", fr, 32'h8000_4000);
        strobe_edge();
        check("e_idle", 32'(busy), 32'd0);

`ifdef LVDS_SEQ_CW_EN
        // Constant carrier: FIFO untouched, ends after transmit drops.
        gap_cfg = 4'd1;
        push(13'h0001, 13'h0000, 1'b0);
        cw_mode = 1'b1;
        @(negedge clk) transmit = 1'b1;
        for (int r = 0; r < 2; r++) begin
            strobe_edge();
            check("f_gap0", fr, 32'h0);
            strobe_edge();
            check("f_gap1", fr, 32'h0);
            strobe_edge();
            check("f_cw", fr, 32'h9FFF_5FFE);
        end
        transmit = 1'b0;
        strobe_edge();
        check("f_trail", fr, 32'h8000_4000);
        check("f_done", 32'(md1), 32'd1);
        strobe_edge();
        check("f_idle", 32'(busy), 32'd0);
        cw_mode = 1'b0;
`else
        // cw_mode must be ignored in this build.
        gap_cfg = 4'd1;
        push(13'h0001, 13'h0000, 1'b0);
        cw_mode = 1'b1;
`endif
        push(13'h0001, 13'h0002, 1'b1);
        tx_pulse();
        strobe_edge();
        strobe_edge();
        strobe_edge();
        check("g_data1", fr, 32'h8003_4000);
        strobe_edge();
        check("g_gap", fr, 32'h0);
        strobe_edge();
        strobe_edge();
        check("g_data2", fr, 32'h8003_4004);
        strobe_edge();
        check("g_trail", fr, 32'h8000_4000);
        strobe_edge();
        check("g_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
